line_event_encoder: RTL and testbench
=====================================

# line_event_encoder

Registered event encoder that sits directly downstream of the 3-to-8 line decoder: it watches the decoder's 8 one-hot output lines, captures every rising edge as a pending event, and emits one 3-bit line code per handshake in round-robin order. It converts bursts of simultaneous or back-to-back line activity into a serialized `Valid`/`Ready` stream of codes (A,B,C) for the control logic, and flags events lost to re-assertion before service.

## Interface
- `NLINES`, 8: number of input lines; fixed at 8 for this revision.
- `CODEW`, 3: code width, log2(`NLINES`).
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Lines`  in  8  decoder output lines; synchronous to `Clock`.
- `Ready`  in  1  consumer accepts the current code this cycle.
- `ClearOvf`  in  1  synchronous clear of `Overflow`.
- `Valid`  out  1  `Code` holds an unserviced event.
- `Code`  out  3  index of the line being reported; `Code[2]`=A, `Code[1]`=B, `Code[0]`=C.
- `Pending`  out  8  events captured but not yet handshaken, including the one on `Code`.
- `Overflow`  out  1  sticky: an event was lost.

## Operation
- Edge detect: `Lines_q` holds the previous `Lines`; `rise = Lines & ~Lines_q`. A line held high produces exactly one event.
- Capture: each clock, `Pending` is updated as `(Pending & ~clr) | rise`, where `clr` is the one-hot bit of `Code` when `Valid & Ready`.
- Overflow: set when `rise[i]` is high, `Pending[i]` is already 1, and bit i is not being cleared this cycle. It stays set until `ClearOvf`. Set beats clear when both occur in the same cycle.
- Simultaneous clear and rise on the same bit: the bit stays 1 as a new event and `Overflow` is not set.
- Round-robin pointer `Ptr` (3 bits) holds the search start. On a handshake, `Ptr` becomes `Code+1` modulo 8, so the pointer wraps from 7 to 0.
- Selection: the first set bit of `Pending` searching upward from `Ptr`, wrapping past 7 to 0. Only bits not being cleared this cycle are eligible.
- FSM, two states:
  - IDLE: `Valid`=0. If any bit of `Pending` is set, load `Code` with the selected index and go to PRESENT.
  - PRESENT: `Valid`=1 and `Code` is held stable until `Ready`.
  - In PRESENT with `Ready`=1: clear the bit and advance `Ptr`. If other bits are still pending, load the next code and stay in PRESENT, giving back-to-back service. Otherwise go to IDLE.
- `Ready` is ignored in IDLE.
- Reset values: `Valid`=0, `Code`=0, `Pending`=0, `Overflow`=0, `Ptr`=0, `Lines_q`=0, state IDLE.
- Reset mid-operation discards all pending events without emitting them.
- `Lines` high at reset release registers as a rising edge on the first clock.

## Timing
- Latency: `Lines[i]` rises before clock edge k, so `Pending[i]`=1 after edge k and `Valid`=1 with `Code`=i after edge k+1.
- Throughput: one code per cycle while `Ready` is held at 1 and events are pending.
- A handshake completes on the rising edge where `Valid & Ready` = 1. The next code, if any, is visible after that same edge.
- `Valid` never deasserts without a handshake, except on reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `line_event_pkg`:
  - `NLINES` and `CODEW` constants.
  - `state_t` enum {IDLE, PRESENT}.
  - Type `code_t` of width `CODEW`.
- Sub-module `rr_pick8`: combinational round-robin picker.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `any`, `idx[2:0]`.
  - Implement as a rotate, then a priority encode, then an add-back of `ptr`.
- Top level holds the edge register, the pending register, the FSM, the pointer and the overflow logic.

## Test plan
- Single event: after reset, `Lines`=00000100 for one cycle with `Ready`=1 → `Valid`=1 with `Code`=2 two edges later, for exactly one cycle. `Pending` returns to 0.
- Burst with round-robin:
  - Stimulus: `Lines`=10010001 in one cycle, `Ready`=1.
  - Required: codes 0, 4, 7 on consecutive cycles, then `Valid`=0.
  - Follow-up: a new `Lines`=00000001 pulse → code 0, after the pointer has wrapped from 7.
- Backpressure: `Lines`=00001000 and `Ready`=0 for 5 cycles → `Valid`=1 and `Code`=3 held stable. Raising `Ready` completes the handshake within one cycle.
- Overflow:
  - Stimulus: with `Ready`=0, pulse `Lines[5]` twice (0→1→0→1).
  - Required: `Overflow`=1 and `Pending[5]`=1, with only one code 5 emitted.
  - Then: `ClearOvf`=1 → `Overflow`=0 on the next edge.
- Clear/rise collision: with `Code`=6 presented, assert `Ready`=1 in the same cycle `Lines[6]` rises again → `Overflow` stays 0 and code 6 is emitted a second time.
- Reset mid-burst: `Lines`=11111111 pulse, `Resetn`=0 after 2 codes → all outputs 0 immediately. After release with `Lines`=0, no further codes are emitted.

Source files
------------

// File: rtl/line_event_pkg.sv
// line_event_pkg: shared constants and types for the line event encoder.
//   NLINES  - number of decoder lines watched (fixed at 8)
//   CODEW   - width of a line code, log2(NLINES)
//   state_t - encoder FSM state
//   code_t  - one line code
package line_event_pkg;

  localparam int NLINES = 8;
  localparam int CODEW  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  typedef logic [CODEW-1:0] code_t;

  // One-hot mask for a line code.
  function automatic logic [NLINES-1:0] code_onehot(input code_t c);
    logic [NLINES-1:0] m;
    m    = '0;
    m[c] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker over 8 requests.
//   req - request vector
//   ptr - search start; the first set bit at or above ptr wins, wrapping 7 -> 0
//   any - at least one request is set
//   idx - index of the winning request (meaningless when any = 0)
// Built as rotate-right by ptr, lowest-set-bit priority encode, then add ptr
// back so the encoded position maps to the original bit index.
module rr_pick8
  import line_event_pkg::*;
(
  input  logic [NLINES-1:0] req,
  input  code_t             ptr,
  output logic              any,
  output code_t             idx
);

  logic [2*NLINES-1:0] dbl;
  logic [NLINES-1:0]   rot;
  code_t               enc;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NLINES-1:0];
    enc = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (rot[i]) enc = code_t'(i);
    end
    any = |req;
    idx = enc + ptr;
  end

endmodule

// File: rtl/line_event_encoder.sv
// line_event_encoder: captures rising edges on the decoder's one-hot output
// lines as pending events and serializes them as 3-bit codes, round-robin.
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   lines      - decoder output lines, synchronous to clk
//   ready      - consumer accepts the current code this cycle
//   clear_ovf  - synchronous clear of overflow (a new loss in the same cycle wins)
//   valid      - code holds an unserviced event
//   code       - line index being reported ({A,B,C} = code[2:0])
//   pending    - captured events not yet handshaken, including the one on code
//   overflow   - sticky: an event re-asserted before its first one was serviced
//   dbg_state  - current FSM state
//
// Handshake: a code transfers on the rising edge where valid & ready are both
// 1. Once valid rises, code is held stable until that edge; valid only drops
// after a transfer (or on reset). ready is ignored while valid is 0.
module line_event_encoder
  import line_event_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLINES-1:0] lines,
  input  logic              ready,
  input  logic              clear_ovf,
  output logic              valid,
  output code_t             code,
  output logic [NLINES-1:0] pending,
  output logic              overflow,
  output state_t            dbg_state
);

  state_t            state;
  code_t             ptr;
  logic [NLINES-1:0] lines_q;

  logic [NLINES-1:0] rise;
  logic              hs;
  logic [NLINES-1:0] clr;
  logic [NLINES-1:0] pending_n;
  logic [NLINES-1:0] eligible;
  logic              lost;
  code_t             ptr_adv;
  code_t             pick_ptr;
  logic              pick_any;
  code_t             pick_idx;

  always_comb begin
    rise      = lines & ~lines_q;
    hs        = (state == PRESENT) && ready;
    clr       = hs ? code_onehot(code) : '0;
    // A rise on a bit being cleared this cycle re-arms it as a fresh event.
    pending_n = (pending & ~clr) | rise;
    lost      = |(rise & pending & ~clr);
    ptr_adv   = code + 1'b1;
    // The next code is chosen from the registered pending set minus the bit
    // leaving now; rises this cycle become eligible one cycle later.
    eligible  = pending & ~clr;
    pick_ptr  = hs ? ptr_adv : ptr;
  end

  rr_pick8 u_pick (
    .req (eligible),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= 1'b0;
      code     <= '0;
      ptr      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      lines_q  <= '0;
    end else begin
      lines_q <= lines;
      pending <= pending_n;

      if (lost) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            code  <= pick_idx;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready) begin
            ptr <= ptr_adv;
            if (pick_any) begin
              code <= pick_idx;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_line_event_encoder.sv
// tb_line_event_encoder: directed-vector bench for line_event_encoder.
// Outputs are sampled and inputs driven 1 ns after each rising clock edge.
module tb_line_event_encoder;
  import line_event_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [NLINES-1:0] lines;
  logic              ready;
  logic              clear_ovf;
  logic              valid;
  code_t             code;
  logic [NLINES-1:0] pending;
  logic              overflow;
  state_t            dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // {valid, code, pending, overflow} packed for compact comparisons
  logic [12:0] got;
  logic [12:0] exp;

  line_event_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lines     (lines),
    .ready     (ready),
    .clear_ovf (clear_ovf),
    .valid     (valid),
    .code      (code),
    .pending   (pending),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {valid, code, pending, overflow};

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    lines     = '0;
    ready     = 1'b0;
    clear_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    exp = {1'b0, 3'd0, 8'h00, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, exp);
    end
    n_vec++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_single();
    apply_reset();
    ready = 1'b1;
    lines = 8'b0000_0100;
    tick();
    lines = '0;
    exp = {1'b0, 3'd0, 8'h04, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL single_capture: got %h expected %h", got, exp);
    end
    tick();
    exp = {1'b1, 3'd2, 8'h04, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL single_present: got %h expected %h", got, exp);
    end
    tick();
    exp = {1'b0, 3'd2, 8'h00, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL single_done: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_burst();
    logic [2:0] want [3];
    want[0] = 3'd0;
    want[1] = 3'd4;
    want[2] = 3'd7;
    apply_reset();
    ready = 1'b1;
    lines = 8'b1001_0001;
    tick();
    lines = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (valid !== 1'b1 || code !== want[i]) begin
        n_err++;
        $display("FAIL burst_code%0d: got valid=%b code=%0d expected valid=1 code=%0d",
                 i, valid, code, want[i]);
      end
      tick();
    end
    exp = {1'b0, 3'd7, 8'h00, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL burst_end: got %h expected %h", got, exp);
    end
    // pointer wrapped 7 -> 0: a new event on line 0 is served next
    lines = 8'b0000_0001;
    tick();
    lines = '0;
    tick();
    exp = {1'b1, 3'd0, 8'h01, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL burst_wrap: got %h expected %h", got, exp);
    end
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL burst_wrap_end: got valid=%b expected 0", valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready = 1'b0;
    lines = 8'b0000_1000;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, 3'd3, 8'h08, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %h expected %h", i, got, exp);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    exp = {1'b0, 3'd3, 8'h00, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL bp_release: got %h expected %h", got, exp);
    end
    lines = '0;
  endtask

  task automatic test_overflow();
    apply_reset();
    ready = 1'b0;
    lines = 8'b0010_0000;
    tick();
    lines = '0;
    tick();
    exp = {1'b1, 3'd5, 8'h20, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ovf_first: got %h expected %h", got, exp);
    end
    lines = 8'b0010_0000;
    tick();
    exp = {1'b1, 3'd5, 8'h20, 1'b1};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ovf_set: got %h expected %h", got, exp);
    end
    lines = '0;
    ready = 1'b1;
    tick();
    exp = {1'b0, 3'd5, 8'h00, 1'b1};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ovf_one_code: got %h expected %h", got, exp);
    end
    tick();
    n_vec++;
    if (valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got valid=%b ovf=%b expected valid=0 ovf=1", valid, overflow);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    ready = 1'b0;
    lines = 8'b0100_0000;
    tick();
    lines = '0;
    tick();
    exp = {1'b1, 3'd6, 8'h40, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL coll_present: got %h expected %h", got, exp);
    end
    ready = 1'b1;
    lines = 8'b0100_0000;
    tick();
    exp = {1'b0, 3'd6, 8'h40, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL coll_rearm: got %h expected %h", got, exp);
    end
    tick();
    lines = '0;
    exp = {1'b1, 3'd6, 8'h40, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL coll_second: got %h expected %h", got, exp);
    end
    tick();
    exp = {1'b0, 3'd6, 8'h00, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL coll_end: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    ready = 1'b1;
    lines = 8'hff;
    tick();
    lines = '0;
    tick();
    n_vec++;
    if (valid !== 1'b1 || code !== 3'd0) begin
      n_err++;
      $display("FAIL mid_code0: got valid=%b code=%0d expected valid=1 code=0", valid, code);
    end
    tick();
    n_vec++;
    if (valid !== 1'b1 || code !== 3'd1) begin
      n_err++;
      $display("FAIL mid_code1: got valid=%b code=%0d expected valid=1 code=1", valid, code);
    end
    tick();
    // two codes handed over; assert reset away from the clock edge
    rst_n = 1'b0;
    #1;
    exp = {1'b0, 3'd0, 8'h00, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_reset_async: got %h expected %h", got, exp);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0 || pending !== 8'h00) begin
        n_err++;
        $display("FAIL mid_quiet%0d: got valid=%b pending=%h expected 0/00", i, valid, pending);
      end
    end
    // a line already high at reset release counts as a rising edge
    rst_n = 1'b0;
    lines = 8'b0000_0010;
    tick();
    rst_n = 1'b1;
    tick();
    exp = {1'b0, 3'd0, 8'h02, 1'b0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL release_edge: got %h expected %h", got, exp);
    end
    tick();
    lines = '0;
    n_vec++;
    if (valid !== 1'b1 || code !== 3'd1) begin
      n_err++;
      $display("FAIL release_code: got valid=%b code=%0d expected valid=1 code=1", valid, code);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    lines     = '0;
    ready     = 1'b0;
    clear_ovf = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_collision();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
